// File: rtl/gap_scan_engine.sv
// gap_scan_engine: binary-gap analyser coprocessor.
// Captures a DATA_W-bit word on an accepted start and scans it LSB first, one bit
// per cycle. It reports the longest zero run bounded by ones on both sides, and the
// number of such runs that are at least MIN_GAP long.
// Optional feature macro: GAP_POS_EN. When it is defined, the gap_pos port is added
// and reports the start index of the longest gap.
module gap_scan_engine #(
  parameter int DATA_W  = 32,
  parameter int MIN_GAP = 1,
  localparam int GAP_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [GAP_W-1:0]  gap_len,
  output logic [GAP_W-1:0]  gap_cnt
`ifdef GAP_POS_EN
  ,
  output logic [GAP_W-1:0]  gap_pos
`endif
);

  localparam logic [GAP_W-1:0] MIN_GAP_W = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] LAST_IDX  = GAP_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   accept;

  // Shift register of the word. The bit under test is always bit 0, so the
  // scan never has to index the word with a variable.
  logic [DATA_W-1:0] shadow_reg;
  logic [GAP_W-1:0]  idx_reg;
  logic              seen_one_reg;
  logic [GAP_W-1:0]  run_reg;
  logic [GAP_W-1:0]  cnt_reg;
  logic [GAP_W-1:0]  best_len_reg;
`ifdef GAP_POS_EN
  logic [GAP_W-1:0]  best_pos_reg;
  logic [GAP_W-1:0]  best_pos_upd;
`endif

  logic              bit_val;
  logic              last_bit;
  logic              gap_close;
  logic              longer;
  logic [GAP_W-1:0]  cnt_upd;
  logic [GAP_W-1:0]  best_len_upd;
  logic [GAP_W-1:0]  run_upd;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic, start acceptance and status outputs.
  // A start is accepted in IDLE or DONE. A start during SCAN is ignored.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = S_SCAN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-bit gap bookkeeping.
  // The updated values are also what the outputs capture on the last bit, so
  // the final bit's own contribution is never lost.
  always_comb begin
    bit_val      = shadow_reg[0];
    last_bit     = (idx_reg == LAST_IDX);
    gap_close    = bit_val && seen_one_reg && (run_reg >= MIN_GAP_W);
    longer       = gap_close && (run_reg > best_len_reg);
    cnt_upd      = gap_close ? cnt_reg + 1'b1 : cnt_reg;
    best_len_upd = longer ? run_reg : best_len_reg;
`ifdef GAP_POS_EN
    best_pos_upd = longer ? idx_reg - run_reg : best_pos_reg;
`endif
    if (bit_val) begin
      run_upd = '0;
    end else if (seen_one_reg) begin
      run_upd = run_reg + 1'b1;
    end else begin
      run_upd = run_reg;
    end
  end

  // Working registers and result registers.
  // The results change only on the final scan cycle and hold through any later scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_reg   <= '0;
      idx_reg      <= '0;
      seen_one_reg <= 1'b0;
      run_reg      <= '0;
      cnt_reg      <= '0;
      best_len_reg <= '0;
      gap_len      <= '0;
      gap_cnt      <= '0;
`ifdef GAP_POS_EN
      best_pos_reg <= '0;
      gap_pos      <= '0;
`endif
    end else if (accept) begin
      shadow_reg   <= data;
      idx_reg      <= '0;
      seen_one_reg <= 1'b0;
      run_reg      <= '0;
      cnt_reg      <= '0;
      best_len_reg <= '0;
`ifdef GAP_POS_EN
      best_pos_reg <= '0;
`endif
    end else if (state_reg == S_SCAN) begin
      shadow_reg   <= shadow_reg >> 1;
      idx_reg      <= idx_reg + 1'b1;
      seen_one_reg <= seen_one_reg | bit_val;
      run_reg      <= run_upd;
      cnt_reg      <= cnt_upd;
      best_len_reg <= best_len_upd;
`ifdef GAP_POS_EN
      best_pos_reg <= best_pos_upd;
`endif
      if (last_bit) begin
        gap_len <= best_len_upd;
        gap_cnt <= cnt_upd;
`ifdef GAP_POS_EN
        gap_pos <= best_pos_upd;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gap_scan_engine.sv
// Testbench for gap_scan_engine.
// Two instances share the same stimulus: dut_a uses MIN_GAP=1 and dut_b uses MIN_GAP=3.
// Expected results come from a list-of-ones reference model.
// The gap_pos checks are compiled only when GAP_POS_EN is defined.
module tb_gap_scan_engine;

  localparam int DATA_W = 32;
  localparam int GAP_W  = $clog2(DATA_W + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              busy_a, done_a, busy_b, done_b;
  logic [GAP_W-1:0]  len_a, cnt_a, len_b, cnt_b;
`ifdef GAP_POS_EN
  logic [GAP_W-1:0]  pos_a, pos_b;
`endif

  int checks = 0;
  int errors = 0;

  // Result values that each DUT should be holding before the current scan completes.
  int hl_a = 0, hc_a = 0, hp_a = 0;
  int hl_b = 0, hc_b = 0, hp_b = 0;

  always #5 clk = ~clk;

  gap_scan_engine #(.DATA_W(DATA_W), .MIN_GAP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy_a), .done(done_a), .gap_len(len_a), .gap_cnt(cnt_a)
`ifdef GAP_POS_EN
    , .gap_pos(pos_a)
`endif
  );

  gap_scan_engine #(.DATA_W(DATA_W), .MIN_GAP(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy_b), .done(done_b), .gap_len(len_b), .gap_cnt(cnt_b)
`ifdef GAP_POS_EN
    , .gap_pos(pos_b)
`endif
  );

  // Reference model.
  // It lists the positions of the ones. Each pair of neighbouring ones encloses one
  // gap, and the first gap of maximal length wins.
  task automatic ref_model(input logic [DATA_W-1:0] w, input int min_gap,
                           output int len, output int cnt, output int pos);
    int ones[$];
    int g;
    len = 0; cnt = 0; pos = 0;
    for (int i = 0; i < DATA_W; i++) if (w[i]) ones.push_back(i);
    for (int k = 1; k < ones.size(); k++) begin
      g = ones[k] - ones[k-1] - 1;
      if (g >= min_gap && g > 0) begin
        cnt++;
        if (g > len) begin
          len = g;
          pos = ones[k-1] + 1;
        end
      end
    end
  endtask

  // Scan one word, starting at a negedge.
  // The task expects the DUTs to be in IDLE or DONE when it is called.
  // It returns at the negedge of the done cycle.
  task automatic run_scan(input logic [DATA_W-1:0] w, input bit mid_start, input string name);
    int el_a, ec_a, ep_a, el_b, ec_b, ep_b;
    int done_cyc;
    bit busy_ok, hold_ok;
    done_cyc = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    ref_model(w, 1, el_a, ec_a, ep_a);
    ref_model(w, 3, el_b, ec_b, ep_b);
    start = 1'b1;
    data  = w;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        data  = $urandom;
      end
      if (mid_start && cyc == 10) begin
        start = 1'b1;
        data  = $urandom;
      end
      if (mid_start && cyc == 11) start = 1'b0;
      if (done_a === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (busy_a !== 1'b1 || busy_b !== 1'b1 || done_b !== 1'b0) busy_ok = 1'b0;
      if (len_a !== GAP_W'(hl_a) || cnt_a !== GAP_W'(hc_a) ||
          len_b !== GAP_W'(hl_b) || cnt_b !== GAP_W'(hc_b)) hold_ok = 1'b0;
`ifdef GAP_POS_EN
      if (pos_a !== GAP_W'(hp_a) || pos_b !== GAP_W'(hp_b)) hold_ok = 1'b0;
`endif
    end
    checks++;
    if (done_cyc != 33) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles, expected 33 (data=%h)", name, done_cyc, w);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_during_scan: busy/done not 1/0 on every scan cycle (data=%h)", name, w);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s hold_during_scan: outputs changed before done (data=%h)", name, w);
    end
    checks++;
    if (done_b !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle_status: done_b=%b busy_a=%b busy_b=%b, expected 1 0 0", name, done_b, busy_a, busy_b);
    end
    checks++;
    if (len_a !== GAP_W'(el_a) || cnt_a !== GAP_W'(ec_a)) begin
      errors++;
      $display("FAIL %s result_min1: len=%0d cnt=%0d, expected len=%0d cnt=%0d (data=%h)", name, len_a, cnt_a, el_a, ec_a, w);
    end
    checks++;
    if (len_b !== GAP_W'(el_b) || cnt_b !== GAP_W'(ec_b)) begin
      errors++;
      $display("FAIL %s result_min3: len=%0d cnt=%0d, expected len=%0d cnt=%0d (data=%h)", name, len_b, cnt_b, el_b, ec_b, w);
    end
`ifdef GAP_POS_EN
    checks++;
    if (pos_a !== GAP_W'(ep_a) || pos_b !== GAP_W'(ep_b)) begin
      errors++;
      $display("FAIL %s result_pos: pos_a=%0d pos_b=%0d, expected %0d %0d (data=%h)", name, pos_a, pos_b, ep_a, ep_b, w);
    end
`endif
    $display("scan %s data=%h len=%0d cnt=%0d | min3 len=%0d cnt=%0d", name, w, len_a, cnt_a, len_b, cnt_b);
    hl_a = el_a; hc_a = ec_a; hp_a = ep_a;
    hl_b = el_b; hc_b = ec_b; hp_b = ep_b;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || len_a !== '0 || cnt_a !== '0 ||
        busy_b !== 1'b0 || done_b !== 1'b0 || len_b !== '0 || cnt_b !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b len=%0d cnt=%0d, expected all 0", busy_a, done_a, len_a, cnt_a);
    end
`ifdef GAP_POS_EN
    checks++;
    if (pos_a !== '0 || pos_b !== '0) begin
      errors++;
      $display("FAIL reset_pos: pos_a=%0d pos_b=%0d, expected 0", pos_a, pos_b);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic();
    run_scan(32'h0000_0201, 1'b0, "basic");
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b busy=%b one cycle after done, expected 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_edges();
    logic [DATA_W-1:0] words [5];
    words[0] = 32'h0000_0000; words[1] = 32'hFFFF_FFFF; words[2] = 32'h8000_0001;
    words[3] = 32'h0000_0014; words[4] = 32'h0000_0049;
    for (int i = 0; i < 5; i++) begin
      run_scan(words[i], 1'b0, "edge");
      @(negedge clk);
    end
  endtask

  task automatic test_min_gap();
    run_scan(32'h0000_0125, 1'b0, "mingap");
    @(negedge clk);
    run_scan(32'h0000_0421, 1'b0, "mingap");
    @(negedge clk);
  endtask

  task automatic test_mid_start();
    run_scan(32'h0100_8421, 1'b1, "midstart");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_scan(32'h0004_0081, 1'b0, "b2b_first");
    run_scan(32'h9000_1003, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_midscan();
    bit no_done;
    no_done = 1'b1;
    start = 1'b1;
    data  = 32'h0020_0401;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || done_a !== 1'b0 ||
        len_a !== '0 || cnt_a !== '0 || len_b !== '0 || cnt_b !== '0) begin
      errors++;
      $display("FAIL reset_midscan_immediate: busy=%b len=%0d cnt=%0d, expected 0 0 0", busy_a, len_a, cnt_a);
    end
`ifdef GAP_POS_EN
    checks++;
    if (pos_a !== '0 || pos_b !== '0) begin
      errors++;
      $display("FAIL reset_midscan_pos: pos_a=%0d, expected 0", pos_a);
    end
`endif
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || done_b !== 1'b0) no_done = 1'b0;
    end
    rst = 1'b1;
    hl_a = 0; hc_a = 0; hp_a = 0;
    hl_b = 0; hc_b = 0; hp_b = 0;
    for (int cyc = 0; cyc < 36; cyc++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) no_done = 1'b0;
    end
    checks++;
    if (!no_done) begin
      errors++;
      $display("FAIL reset_midscan_no_done: done or busy seen after aborted scan, expected none");
    end
    $display("reset mid-scan aborted, idle confirmed");
    run_scan(32'h0040_0101, 1'b0, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0: w = $urandom;
        1: w = $urandom & $urandom & $urandom;
        default: w = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31)) |
                     (32'h1 << $urandom_range(0, 31));
      endcase
      run_scan(w, 1'b0, "random");
      if (i % 2 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_min_gap();
    test_mid_start();
    test_back_to_back();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
